// File: rtl/inst_sram_responder.sv
// inst_sram_responder
//   Responder end of the instruction SRAM interface. Holds a word-organised
//   memory mapped at BASE_ADDR, answers every enabled access with read data
//   one cycle later, supports byte-masked writes, optionally zeroes the whole
//   array after reset, and keeps debug counters for out-of-range accesses.
//
// Ports:
//   clk              clock
//   resetn           asynchronous active-low reset
//   inst_sram_en     access request this cycle
//   inst_sram_wen    byte write enables, bit i covers wdata[8i+7:8i]
//   inst_sram_addr   byte address
//   inst_sram_wdata  write data
//   inst_sram_rdata  read data, valid the cycle after en
//   init_busy        clear sequence in progress
//   oor_err          sticky out-of-range flag
//   oor_cnt          saturating out-of-range access count
//   err_clr          synchronous clear of oor_err / oor_cnt
//
// Clear FSM:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zeroing mem[clr_idx] each cycle; accesses ignored, rdata 0
//   ST_RUN  | normal operation
module inst_sram_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'hbfc00000,
  parameter int          DEPTH          = 4096,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        init_busy,
  output logic        oor_err,
  output logic [15:0] oor_cnt,
  input  logic        err_clr
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [31:0]   mem [DEPTH];

  logic [0:0]    state_q;
  logic [AW-1:0] clr_idx;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          acc_ok;
  logic          acc_oor;

  // Wrap-around subtraction: addresses below BASE_ADDR become huge offsets
  // and therefore fall out of range without a separate lower-bound compare.
  assign off      = inst_sram_addr - BASE_ADDR;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[AW+1:2];

  assign init_busy = (state_q == ST_INIT);
  assign acc_ok    = inst_sram_en && !init_busy && in_range;
  assign acc_oor   = inst_sram_en && !init_busy && !in_range;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RST;
      clr_idx <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH - 1))
            state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_idx] <= '0;
    end else if (acc_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i])
          mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read-first: the nonblocking read samples the word before this edge's write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= '0;
    end else if (inst_sram_en) begin
      if (acc_ok)
        inst_sram_rdata <= mem[idx];
      else
        inst_sram_rdata <= '0;
    end
  end

  // err_clr takes priority over a coincident out-of-range access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_err <= 1'b0;
      oor_cnt <= '0;
    end else if (err_clr) begin
      oor_err <= 1'b0;
      oor_cnt <= '0;
    end else if (acc_oor) begin
      oor_err <= 1'b1;
      if (oor_cnt != 16'hffff)
        oor_cnt <= oor_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
module tb_inst_sram_responder;

  localparam logic [31:0] BASE  = 32'hbfc00000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        init_busy;
  logic        oor_err;
  logic [15:0] oor_cnt;
  logic        err_clr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_sram_responder #(
    .BASE_ADDR(BASE),
    .DEPTH(DEPTH),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .init_busy(init_busy),
    .oor_err(oor_err),
    .oor_cnt(oor_cnt),
    .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every enabled edge must produce the next queued response.
  initial begin
    logic was_en;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      was_en = inst_sram_en && resetn;
      #1;
      if (was_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_unexpected: got 0x%08h with no queued expectation", inst_sram_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", inst_sram_rdata, e);
        end
      end
    end
  end

  task automatic acc(input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp,
                     input logic clr = 1'b0);
    @(negedge clk);
    inst_sram_en    = 1'b1;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    err_clr         = clr;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      inst_sram_en = 1'b0;
      inst_sram_wen = 4'h0;
      err_clr = 1'b0;
    end
  endtask

  task automatic count_busy(input string name);
    int cyc = 0;
    while (init_busy && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      inst_sram_en = 1'b0;
      inst_sram_wen = 4'h0;
    end
    chk(name, 32'(cyc), 32'(DEPTH));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    inst_sram_en = 1'b0;
    inst_sram_wen = 4'h0;
    inst_sram_addr = '0;
    inst_sram_wdata = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_oor_err", 32'(oor_err), 32'h0);
    chk("rst_oor_cnt", 32'(oor_cnt), 32'h0);
    chk("rst_init_busy", 32'(init_busy), 32'h1);

    // Release reset with a write attempted during the clear.
    @(negedge clk);
    resetn = 1'b1;
    inst_sram_en = 1'b1;
    inst_sram_wen = 4'hf;
    inst_sram_addr = BASE;
    inst_sram_wdata = 32'hdeadbeef;
    exp_q.push_back(32'h0);
    count_busy("init_busy_cycles");

    acc(4'h0, BASE, 0, 32'h0);                       // busy write ignored
    // Byte-masked write.
    acc(4'hf, BASE + 8, 32'h11223344, 32'h0);
    acc(4'b0101, BASE + 8, 32'haabbccdd, 32'h11223344);
    acc(4'h0, BASE + 8, 0, 32'h11bb33dd);
    // Read-first and back-to-back.
    acc(4'hf, BASE + 4, 32'h1, 32'h0);
    acc(4'hf, BASE + 4, 32'h2, 32'h1);
    acc(4'h0, BASE + 4, 0, 32'h2);
    idle(1);
    repeat (3) begin
      @(negedge clk);
      chk("rdata_hold", inst_sram_rdata, 32'h2);
    end
    // Last in-range word.
    acc(4'hf, BASE + 60, 32'h5a5a5a5a, 32'h0);
    acc(4'h0, BASE + 60, 0, 32'h5a5a5a5a);

    // Out of range.
    acc(4'h0, BASE + DEPTH*4, 0, 32'h0);
    acc(4'h0, 32'h0, 0, 32'h0);
    idle(1);
    chk("oor_err_set", 32'(oor_err), 32'h1);
    chk("oor_cnt_2", 32'(oor_cnt), 32'd2);
    acc(4'hf, BASE + DEPTH*4, 32'hcafef00d, 32'h0);
    acc(4'hf, BASE - 4, 32'hcafef00d, 32'h0);
    acc(4'h0, BASE, 0, 32'h0);
    acc(4'h0, BASE + 4, 0, 32'h2);
    acc(4'h0, BASE + 60, 0, 32'h5a5a5a5a);
    acc(4'h0, BASE + 8, 0, 32'h11bb33dd);
    idle(1);
    chk("oor_cnt_4", 32'(oor_cnt), 32'd4);
    acc(4'h0, 32'h0, 0, 32'h0, 1'b1);
    idle(1);
    chk("clr_oor_cnt", 32'(oor_cnt), 32'h0);
    chk("clr_oor_err", 32'(oor_err), 32'h0);

    // Async reset mid-operation.
    acc(4'h0, 32'h4, 0, 32'h0);
    acc(4'h0, BASE + 4, 0, 32'h2);
    idle(1);
    chk("pre_rst_rdata", inst_sram_rdata, 32'h2);
    chk("pre_rst_cnt", 32'(oor_cnt), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_rdata", inst_sram_rdata, 32'h0);
    chk("async_rst_cnt", 32'(oor_cnt), 32'h0);
    chk("async_rst_busy", 32'(init_busy), 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    count_busy("init_busy_cycles_2");

    // Saturation.
    repeat (65534) acc(4'h0, 32'h0, 0, 32'h0);
    idle(1);
    chk("oor_cnt_fffe", 32'(oor_cnt), 32'h0000fffe);
    repeat (3) acc(4'h0, 32'h0, 0, 32'h0);
    idle(1);
    chk("oor_cnt_sat", 32'(oor_cnt), 32'h0000ffff);
    chk("oor_err_sat", 32'(oor_err), 32'h1);

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
